// File: rtl/histogram_accum_p.sv
// histogram_accum_p: streams one frame of packed pixels from source memory and
// counts every pixel value into an external bin memory. Optional clear phase,
// saturating counters, accumulate-across-frames mode, start/busy/done handshake.
//
// Handshake: start is a one-cycle pulse that is accepted only in IDLE; busy is
// high from the cycle after acceptance until the done cycle; done pulses for one
// cycle once the last bin write has been issued, and busy is already low then.
module histogram_accum_p #(
  parameter int PIX_W     = 8,
  parameter int LANES     = 16,
  parameter int NUM_WORDS = 19200,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 20
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   accumulate,
  input  logic [ADDR_W-1:0]      src_base,
  output logic [ADDR_W-1:0]      src_rd_addr,
  input  logic [PIX_W*LANES-1:0] src_rd_data,
  output logic [PIX_W-1:0]       bin_rd_addr,
  input  logic [CNT_W-1:0]       bin_rd_data,
  output logic                   bin_wr_en,
  output logic [PIX_W-1:0]       bin_wr_addr,
  output logic [CNT_W-1:0]       bin_wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag,
  output logic [2:0]             state_dbg
);

  localparam int SRC_W  = PIX_W * LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PREFETCH = 3'd2,
    S_COUNT    = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [LANE_W-1:0] lane_q;
  logic [WORD_W-1:0] word_q;
  logic [SRC_W-1:0]  buf_q;

  // F stage (bin read in flight), W stage (write on the bus), P (last cycle's write)
  logic              f_valid;
  logic [PIX_W-1:0]  f_addr;
  logic              w_en;
  logic [PIX_W-1:0]  w_addr;
  logic [CNT_W-1:0]  w_data;
  logic              p_en;
  logic [PIX_W-1:0]  p_addr;
  logic [CNT_W-1:0]  p_data;
  logic              sat_q;

  logic              last_lane;
  logic              last_word;
  logic [PIX_W-1:0]  pixel;
  logic [CNT_W-1:0]  old_cnt;
  logic [CNT_W-1:0]  new_cnt;
  logic              accept;

  assign accept    = (state == S_IDLE) && start;
  assign last_lane = (lane_q == LAST_LANE);
  assign last_word = (word_q == LAST_WORD);

  // Lane 0 comes straight off the source bus; later lanes from the shifted buffer.
  assign pixel = (lane_q == '0) ? src_rd_data[PIX_W-1:0] : buf_q[PIX_W-1:0];

  // Old count for the F stage: a write on the bus now beats the write from last
  // cycle, which beats the memory (the memory missed both of them).
  always_comb begin
    old_cnt = bin_rd_data;
    if (w_en && (w_addr == f_addr)) begin
      old_cnt = w_data;
    end else if (p_en && (p_addr == f_addr)) begin
      old_cnt = p_data;
    end
    new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + CNT_W'(1);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = accumulate ? S_PREFETCH : S_CLEAR;
      S_CLEAR:    if (&w_addr) state_nx = S_PREFETCH;
      S_PREFETCH: state_nx = S_COUNT;
      S_COUNT:    if (last_lane && last_word) state_nx = S_DRAIN;
      S_DRAIN:    if (!f_valid) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Output decode: source/bin read addresses and handshake flags.
  always_comb begin
    src_rd_addr = '0;
    if (state == S_PREFETCH) begin
      src_rd_addr = base_q;
    end else if ((state == S_COUNT) && last_lane && !last_word) begin
      src_rd_addr = base_q + ADDR_W'(word_q) + ADDR_W'(1);
    end
    bin_rd_addr = (state == S_COUNT) ? pixel : '0;
    busy        = (state == S_CLEAR) || (state == S_PREFETCH) ||
                  (state == S_COUNT) || (state == S_DRAIN);
    done        = (state == S_DONE);
  end

  assign bin_wr_en   = w_en;
  assign bin_wr_addr = w_addr;
  assign bin_wr_data = w_data;
  assign sat_flag    = sat_q;
  assign state_dbg   = state;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Frame walk: latched base, lane/word counters and the shifting word buffer.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      lane_q <= '0;
      word_q <= '0;
      buf_q  <= '0;
    end else begin
      if (accept) base_q <= src_base;
      if (state == S_PREFETCH) begin
        lane_q <= '0;
        word_q <= '0;
      end else if (state == S_COUNT) begin
        buf_q <= ((lane_q == '0) ? src_rd_data : buf_q) >> PIX_W;
        if (last_lane) begin
          lane_q <= '0;
          word_q <= word_q + WORD_W'(1);
        end else begin
          lane_q <= lane_q + LANE_W'(1);
        end
      end
    end
  end

  // Count pipeline plus clear writes; both share the registered W stage.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      f_valid <= 1'b0;
      f_addr  <= '0;
      w_en    <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      p_en    <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
    end else begin
      f_valid <= (state == S_COUNT);
      f_addr  <= pixel;
      p_en    <= w_en;
      p_addr  <= w_addr;
      p_data  <= w_data;
      if (accept && !accumulate) begin
        w_en   <= 1'b1;
        w_addr <= '0;
        w_data <= '0;
      end else if ((state == S_CLEAR) && !(&w_addr)) begin
        w_en   <= 1'b1;
        w_addr <= w_addr + PIX_W'(1);
        w_data <= '0;
      end else if (f_valid) begin
        w_en   <= 1'b1;
        w_addr <= f_addr;
        w_data <= new_cnt;
      end else begin
        w_en   <= 1'b0;
      end
    end
  end

  // Saturation flag: cleared by an accepted start, set when a bin reaches max.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= 1'b0;
    end else if (f_valid && (new_cnt == CNT_MAX)) begin
      sat_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_histogram_accum_p.sv
// Bench for histogram_accum_p: bench-owned source/bin memories, a frame-level
// histogram model producing the expected write stream and done timing, and a
// per-cycle compare process.
module tb_histogram_accum_p;

  localparam int PIX_W = 4, LANES = 4, NUM_WORDS = 2, ADDR_W = 8, CNT_W = 4;
  localparam int B = 16, N = 8;
  localparam int EW = 16 + PIX_W + CNT_W;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic                   clock = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   accumulate;
  logic [ADDR_W-1:0]      src_base;
  logic [ADDR_W-1:0]      src_rd_addr;
  logic [PIX_W*LANES-1:0] src_rd_data;
  logic [PIX_W-1:0]       bin_rd_addr;
  logic [CNT_W-1:0]       bin_rd_data;
  logic                   bin_wr_en;
  logic [PIX_W-1:0]       bin_wr_addr;
  logic [CNT_W-1:0]       bin_wr_data;
  logic                   busy;
  logic                   done;
  logic                   sat_flag;
  logic [2:0]             state_dbg;

  histogram_accum_p #(
    .PIX_W(PIX_W), .LANES(LANES), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .accumulate(accumulate),
    .src_base(src_base), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .bin_rd_addr(bin_rd_addr), .bin_rd_data(bin_rd_data), .bin_wr_en(bin_wr_en),
    .bin_wr_addr(bin_wr_addr), .bin_wr_data(bin_wr_data), .busy(busy), .done(done),
    .sat_flag(sat_flag), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- memories ----------------
  logic [15:0]      src_mem [256];
  logic [CNT_W-1:0] bin_mem [16];

  always @(posedge clock) begin
    src_rd_data <= src_mem[src_rd_addr];
    bin_rd_data <= bin_mem[bin_rd_addr];
    if (bin_wr_en) bin_mem[bin_wr_addr] <= bin_wr_data;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] hist [16];
  bit  sat_exp;
  bit  run_active = 1'b0;
  int  start_cyc;
  int  done_rel;
  int  done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_src_rd_addr"}, src_rd_addr, 0);
    chk({tag, "_bin_rd_addr"}, bin_rd_addr, 0);
    chk({tag, "_bin_wr_en"},   bin_wr_en, 0);
    chk({tag, "_bin_wr_addr"}, bin_wr_addr, 0);
    chk({tag, "_bin_wr_data"}, bin_wr_data, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_done"},        done, 0);
    chk({tag, "_sat_flag"},    sat_flag, 0);
  endtask

  // Per-cycle compare of write bus, busy, done and sat_flag against the model.
  always @(negedge clock) begin : compare
    int rel;
    logic [EW-1:0] e;
    if (run_active && rst_n) begin
      rel = cyc - start_cyc;
      if (rel >= 1) begin
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 16]) == rel) begin
          e = exp_q.pop_front();
          chk("wr_en", bin_wr_en, 1);
          chk("wr_addr", bin_wr_addr, e[CNT_W +: PIX_W]);
          chk("wr_data", bin_wr_data, e[CNT_W-1:0]);
          if (e[CNT_W-1:0] == MAX) sat_exp = 1'b1;
        end else begin
          chk("wr_idle", bin_wr_en, 0);
        end
        chk("busy", busy, (rel < done_rel) ? 1 : 0);
        chk("done", done, (rel == done_rel) ? 1 : 0);
        chk("sat_flag", sat_flag, sat_exp);
        if (done) done_seen = rel;
      end
    end
  end

  // ---------------- driver ----------------
  // Builds the expected histogram and write stream for one frame, then runs it.
  // With poke set, extra start pulses with random accumulate/base hit mid-run.
  task automatic run_frame(input bit acc, input logic [7:0] base, input bit poke);
    logic [15:0] word;
    logic [3:0]  px;
    int base_rel;
    exp_q.delete();
    if (!acc) begin
      for (int b = 0; b < B; b++) begin
        hist[b] = '0;
        exp_q.push_back({16'(b + 1), 4'(b), CNT_W'(0)});
      end
    end
    base_rel = acc ? 1 : B + 1;
    for (int i = 0; i < N; i++) begin
      word = src_mem[8'(base + 8'(i / LANES))];
      px   = 4'(word >> (4 * (i % LANES)));
      if (hist[px] != MAX) hist[px] = hist[px] + 1'b1;
      exp_q.push_back({16'(base_rel + 3 + i), px, hist[px]});
    end
    done_rel  = base_rel + N + 3;
    done_seen = -1;
    @(negedge clock);
    start_cyc  = cyc;
    sat_exp    = 1'b0;
    run_active = 1'b1;
    start      = 1'b1;
    accumulate = acc;
    src_base   = base;
    for (int i = 0; i <= done_rel; i++) begin
      @(negedge clock);
      start      = poke && (i == 3 || i == 6);
      accumulate = 1'($urandom);
      src_base   = 8'($urandom);
    end
    start = 1'b0;
    @(posedge clock);
    #1;
    run_active = 1'b0;
    chk("writes_remaining", exp_q.size(), 0);
    chk("done_rel", done_seen, done_rel);
    for (int b = 0; b < B; b++) chk("bin_final", bin_mem[b], hist[b]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    logic [3:0]  pa, pb;
    logic [7:0]  base;
    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; src_base = '0;
    for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // Distinct pixels 0..7, clear mode.
    src_mem[8'h10] = 16'h3210; src_mem[8'h11] = 16'h7654;
    run_frame(1'b0, 8'h10, 1'b0);
    chk("t1_done_cycle", done_seen, 28);
    for (int b = 0; b < B; b++) chk("t1_bin", bin_mem[b], (b < 8) ? 1 : 0);

    // Accumulate the same frame on top; start pulses mid-run must be ignored.
    run_frame(1'b1, 8'h10, 1'b1);
    chk("t_acc_done_cycle", done_seen, 12);
    for (int b = 0; b < 8; b++) chk("t_acc_bin", bin_mem[b], 2);

    // All pixels 5: back-to-back same-address forwarding.
    src_mem[8'h20] = 16'h5555; src_mem[8'h21] = 16'h5555;
    run_frame(1'b0, 8'h20, 1'b0);
    chk("t2_model_bin5", hist[5], 8);
    chk("t2_bin5", bin_mem[5], 8);

    // Alternating A,B: previous-write forwarding path.
    src_mem[8'h30] = 16'hBABA; src_mem[8'h31] = 16'hBABA;
    run_frame(1'b0, 8'h30, 1'b1);
    chk("t3_binA", bin_mem[10], 4);
    chk("t3_binB", bin_mem[11], 4);

    // Saturation: 16 pixels of 0xF over two frames with a 4-bit counter.
    src_mem[8'h40] = 16'hFFFF; src_mem[8'h41] = 16'hFFFF;
    run_frame(1'b0, 8'h40, 1'b0);
    chk("t4_sat_first", sat_flag, 0);
    run_frame(1'b1, 8'h40, 1'b0);
    chk("t4_sat_set", sat_flag, 1);
    chk("t4_binF", bin_mem[15], 15);
    run_frame(1'b0, 8'h10, 1'b0);
    chk("t4_sat_cleared", sat_flag, 0);

    // Reset asserted mid-COUNT aborts at once.
    @(negedge clock);
    start = 1'b1; accumulate = 1'b0; src_base = 8'h10;
    @(negedge clock);
    start = 1'b0;
    repeat (B + 4) @(negedge clock);
    chk("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clock);
    chk("mid_reset_no_write", bin_wr_en, 0);
    rst_n = 1'b1;

    // Randomized frames (first one after reset must clear).
    for (int r = 0; r < 24; r++) begin
      base = 8'($urandom);
      pa = 4'($urandom); pb = 4'($urandom);
      for (int k = 0; k < NUM_WORDS; k++) begin
        w = '0;
        for (int l = 0; l < LANES; l++) begin
          if (r % 3 == 0) w[4*l +: 4] = ($urandom_range(0, 1) == 1) ? pa : pb;
          else            w[4*l +: 4] = 4'($urandom_range(0, 15));
        end
        src_mem[8'(base + 8'(k))] = w;
      end
      run_frame((r == 0) ? 1'b0 : 1'($urandom_range(0, 1)), base, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
